sram_dpu: RTL and testbench



---
 rtl/sram_dpu_pkg.sv | 33 +++
 rtl/sram_dpu_if.sv | 27 ++
 rtl/sram_dpu_popcnt.sv | 46 ++++
 rtl/sram_dpu.sv | 120 ++++++++++++
 tb/tb_sram_dpu.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_dpu_pkg.sv
// Shared constants for the SRAM data-processing unit: opcodes, FSM encoding,
// command field positions and the debug view of the FSM.
package dpu_pkg;

   localparam int DPU_DATA_W = 32;
   localparam int DPU_ADDR_W = 5;
   localparam int POP_CNT_W  = 6;

   typedef logic [1:0] dpu_op_t;

   localparam dpu_op_t OP_INC    = 2'b00;
   localparam dpu_op_t OP_NOT    = 2'b01;
   localparam dpu_op_t OP_ROTL8  = 2'b10;
   localparam dpu_op_t OP_POPCNT = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RD_REQ = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_WR_REQ = 2'd3;

   // Command byte layout: [7] DPU tag (not checked), [6:5] opcode, [4:0] address
   localparam int CMD_TAG_BIT = 7;
   localparam int CMD_OP_HI   = 6;
   localparam int CMD_OP_LO   = 5;
   localparam int CMD_ADDR_HI = 4;
   localparam int CMD_ADDR_LO = 0;

   typedef struct packed {
      logic [1:0] state;
      logic [7:0] cmd;
   } dpu_dbg_t;

endpackage

// File: rtl/sram_dpu_if.sv
// Command and SRAM-request bus between the SRAM controller and the DPU.
interface sram_dpu_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) ();
   // Handshake: dpu_load_cmd is a one-cycle strobe qualifying nxt_cmd. read_requst
   // and send_request are held until requst_valid is seen; requst_valid is a
   // one-cycle pulse meaning read data valid (read phase) or write done (write phase).
   logic              dpu_load_cmd;
   logic [7:0]        nxt_cmd;
   logic              requst_valid;
   logic [DATA_W-1:0] sram_data_to_dpu;
   logic              read_requst;
   logic              send_request;
   logic [ADDR_W-1:0] sram_addr_from_dpu;
   logic [DATA_W-1:0] sram_data_from_dpu;

   modport master (
      input  dpu_load_cmd, nxt_cmd, requst_valid, sram_data_to_dpu,
      output read_requst, send_request, sram_addr_from_dpu, sram_data_from_dpu
   );

   modport slave (
      output dpu_load_cmd, nxt_cmd, requst_valid, sram_data_to_dpu,
      input  read_requst, send_request, sram_addr_from_dpu, sram_data_from_dpu
   );
endinterface

// File: rtl/sram_dpu_popcnt.sv
// Serial popcount: one bit per cycle over DATA_W cycles; count is valid while done is high.
module dpu_popcnt
   import dpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_W-1:0]    din,
   output logic                 busy,
   output logic                 done,
   output logic [POP_CNT_W-1:0] count
);
   localparam logic [POP_CNT_W-1:0] LAST = POP_CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0]    r_shift;
   logic [POP_CNT_W-1:0] r_cnt;
   logic [POP_CNT_W-1:0] r_acc;
   logic                 r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_busy  <= 1'b0;
      end else if (start) begin
         r_shift <= din;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         r_shift <= r_shift >> 1;
         r_acc   <= r_acc + {{(POP_CNT_W-1){1'b0}}, r_shift[0]};
         r_cnt   <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_busy <= 1'b0;
      end
   end

   // Final total includes the bit being consumed in the last cycle.
   assign busy  = r_busy;
   assign done  = r_busy && (r_cnt == LAST);
   assign count = r_acc + {{(POP_CNT_W-1){1'b0}}, r_shift[0]};

endmodule

// File: rtl/sram_dpu.sv
// Read-modify-write DPU behind the SRAM controller (INC/NOT/ROTL8/POPCNT).
// Optional: define DPU_POPCNT_EN for serial POPCNT; otherwise opcode 11 writes the word back unchanged.
module sram_dpu
   import dpu_pkg::*;
#(
   parameter int DATA_W = DPU_DATA_W,
   parameter int ADDR_W = DPU_ADDR_W
) (
   input  logic      clk,
   input  logic      rst,
   sram_dpu_if.master bus,
   output logic      busy,
   output logic      done,
   output dpu_dbg_t  o_dbg
);
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   logic [1:0]        r_state;
   logic [7:0]        r_cmd;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_result;
   logic              r_done;

   dpu_op_t           w_op;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_alu;

   assign w_op   = r_cmd[CMD_OP_HI:CMD_OP_LO];
   assign w_addr = r_cmd[CMD_ADDR_HI:CMD_ADDR_LO];

   always_comb begin
      w_alu = r_data;
      case (w_op)
         OP_INC:   w_alu = r_data + ONE;
         OP_NOT:   w_alu = ~r_data;
         OP_ROTL8: w_alu = {r_data[DATA_W-9:0], r_data[DATA_W-1:DATA_W-8]};
         default:  w_alu = r_data;
      endcase
   end

`ifdef DPU_POPCNT_EN
   logic                 w_pop_start;
   logic                 w_pop_busy;
   logic                 w_pop_done;
   logic [POP_CNT_W-1:0] w_pop_count;

   // Popcount loads straight from the read bus so its 32 shifts fill the EXEC window.
   assign w_pop_start = (r_state == ST_RD_REQ) && bus.requst_valid && (w_op == OP_POPCNT);

   dpu_popcnt #(.DATA_W(DATA_W)) u_popcnt (
      .clk   (clk),
      .rst   (rst),
      .start (w_pop_start),
      .din   (bus.sram_data_to_dpu),
      .busy  (w_pop_busy),
      .done  (w_pop_done),
      .count (w_pop_count)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cmd    <= '0;
         r_data   <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.dpu_load_cmd) begin
                  r_cmd   <= bus.nxt_cmd;
                  r_state <= ST_RD_REQ;
               end
            end
            ST_RD_REQ: begin
               if (bus.requst_valid) begin
                  r_data  <= bus.sram_data_to_dpu;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
`ifdef DPU_POPCNT_EN
               if (w_op == OP_POPCNT) begin
                  if (w_pop_busy && w_pop_done) begin
                     r_result <= {{(DATA_W-POP_CNT_W){1'b0}}, w_pop_count};
                     r_state  <= ST_WR_REQ;
                  end
               end else begin
                  r_result <= w_alu;
                  r_state  <= ST_WR_REQ;
               end
`else
               r_result <= w_alu;
               r_state  <= ST_WR_REQ;
`endif
            end
            ST_WR_REQ: begin
               if (bus.requst_valid) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; address and data are zeroed outside their windows.
   assign bus.read_requst        = (r_state == ST_RD_REQ);
   assign bus.send_request       = (r_state == ST_WR_REQ);
   assign bus.sram_addr_from_dpu = (r_state != ST_IDLE) ? w_addr : '0;
   assign bus.sram_data_from_dpu = (r_state == ST_WR_REQ) ? r_result : '0;
   assign busy                   = (r_state != ST_IDLE);
   assign done                   = r_done;
   assign o_dbg.state            = r_state;
   assign o_dbg.cmd              = r_cmd;

endmodule

// File: tb/tb_sram_dpu.sv
// Directed bench for sram_dpu with a behavioural SRAM controller model.
module tb_sram_dpu;
  import dpu_pkg::*;

`ifdef DPU_POPCNT_EN
  localparam logic [31:0] POP_EXP   = 32'h0000000C;
  localparam int          POP_LAT   = 36;
  localparam int          RST_AT    = 11;
  localparam logic [1:0]  RST_STATE = ST_EXEC;
  localparam int          RST_RDDLY = 0;
`else
  localparam logic [31:0] POP_EXP   = 32'hF0F0000F;
  localparam int          POP_LAT   = 5;
  localparam int          RST_AT    = 3;
  localparam logic [1:0]  RST_STATE = ST_RD_REQ;
  localparam int          RST_RDDLY = 8;
`endif

  logic     clk;
  logic     rst;
  logic     busy;
  logic     done;
  dpu_dbg_t dbg;

  sram_dpu_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  sram_dpu #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .o_dbg (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // controller model: samples DUT outputs mid-cycle, answers one cycle later
  logic [31:0] mem [32];
  int          rd_delay = 0;
  int          wr_delay = 0;
  int          wait_cnt = 0;
  int          spur_req = 0;
  int          wr_cnt   = 0;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        s_rr, s_sr, s_rst;
  logic [4:0]  s_a;
  logic [31:0] s_d;

  always @(negedge clk) begin
    s_rr  = bus.read_requst;
    s_sr  = bus.send_request;
    s_a   = bus.sram_addr_from_dpu;
    s_d   = bus.sram_data_from_dpu;
    s_rst = rst;
  end

  always @(posedge clk) begin
    #1;
    if (s_rst) begin
      bus.requst_valid = 1'b0;
      wait_cnt = 0;
    end else if (spur_req != 0) begin
      bus.requst_valid = 1'b1;
      spur_req = 0;
    end else if (bus.requst_valid) begin
      bus.requst_valid = 1'b0;
    end else if (s_rr) begin
      if (wait_cnt < rd_delay) wait_cnt++;
      else begin
        wait_cnt = 0;
        bus.sram_data_to_dpu = mem[s_a];
        bus.requst_valid = 1'b1;
      end
    end else if (s_sr) begin
      if (wait_cnt < wr_delay) wait_cnt++;
      else begin
        wait_cnt = 0;
        mem[s_a] = s_d;
        wr_cnt++;
        wr_addr = s_a;
        wr_data = s_d;
        bus.requst_valid = 1'b1;
      end
    end
  end

  // driver: issue one command, follow it to done, check the write-back
  task automatic run_op(input string tag, input logic [7:0] cmd, input logic [4:0] ea,
                        input logic [31:0] ed, input int elat, input int inj_at,
                        input logic [7:0] inj_cmd, output int sr_cycles);
    int  base;
    int  lat;
    bit  seen;
    base = wr_cnt;
    sr_cycles = 0;
    seen = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.dpu_load_cmd = 1'b1;
    bus.nxt_cmd = cmd;
    @(posedge clk);
    #1;
    bus.dpu_load_cmd = 1'b0;
    bus.nxt_cmd = 8'h00;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat = c;
      end else if (bus.send_request) begin
        sr_cycles++;
        chk({tag, "_wr_addr"}, 64'(bus.sram_addr_from_dpu), 64'(ea));
        chk({tag, "_wr_data"}, 64'(bus.sram_data_from_dpu), 64'(ed));
      end else if (bus.read_requst) begin
        chk({tag, "_rd_addr"}, 64'(bus.sram_addr_from_dpu), 64'(ea));
        chk({tag, "_rd_dq"}, 64'(bus.sram_data_from_dpu), 64'd0);
      end
      bus.dpu_load_cmd = (c == inj_at);
      bus.nxt_cmd = (c == inj_at) ? inj_cmd : 8'h00;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_writes"}, 64'(wr_cnt - base), 64'd1);
    chk({tag, "_mem_addr"}, 64'(wr_addr), 64'(ea));
    chk({tag, "_mem_data"}, 64'(wr_data), 64'(ed));
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {60'd0, bus.read_requst, bus.send_request, busy, done}, 64'd0);
    chk({tag, "_addr"}, 64'(bus.sram_addr_from_dpu), 64'd0);
    chk({tag, "_data"}, 64'(bus.sram_data_from_dpu), 64'd0);
    chk({tag, "_state"}, 64'(dbg.state), 64'(ST_IDLE));
  endtask

  initial begin
    int sr;
    int base;
    int bad;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[1]  = 32'hF0F0000F;
    mem[3]  = 32'h000000FF;
    mem[5]  = 32'h12345678;
    mem[10] = 32'h11223344;
    mem[31] = 32'hFFFFFFFF;
    rst = 1'b1;
    bus.dpu_load_cmd = 1'b0;
    bus.nxt_cmd = 8'h00;
    bus.requst_valid = 1'b0;
    bus.sram_data_to_dpu = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_cmd", 64'(dbg.cmd), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op("inc", 8'h83, 5'd3, 32'h00000100, 5, 0, 8'h00, sr);
    chk("inc_sr_cycles", 64'(sr), 64'd2);
    run_op("not", 8'hA5, 5'd5, 32'hEDCBA987, 5, 0, 8'h00, sr);
    run_op("rotl8", 8'hCA, 5'd10, 32'h22334411, 5, 0, 8'h00, sr);
    run_op("popcnt", 8'hE1, 5'd1, POP_EXP, POP_LAT, 0, 8'h00, sr);

    // write ack stalled 4 cycles: request, address and data must hold
    wr_delay = 4;
    run_op("stall", 8'h9F, 5'd31, 32'h00000000, 9, 0, 8'h00, sr);
    chk("stall_sr_cycles", 64'(sr), 64'd6);
    wr_delay = 0;

    // command while busy is dropped
    run_op("busy_drop", 8'hA5, 5'd5, 32'h12345678, 5, 2, 8'h83, sr);
    base = wr_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("busy_drop_no_busy", 64'(busy), 64'd0);
    chk("busy_drop_no_write", 64'(wr_cnt - base), 64'd0);

    // stray requst_valid in IDLE
    @(posedge clk);
    spur_req = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_idle_busy", 64'(busy), 64'd0);
    chk("spur_idle_write", 64'(wr_cnt - base), 64'd0);

    // requst_valid coincident with load in IDLE: command accepted
    @(posedge clk);
    spur_req = 1;
    run_op("spur_load", 8'hCA, 5'd10, 32'h33441122, 5, 0, 8'h00, sr);

    // reset mid-operation
    rd_delay = RST_RDDLY;
    base = wr_cnt;
    bad = 0;
    @(negedge clk);
    bus.dpu_load_cmd = 1'b1;
    bus.nxt_cmd = 8'hE1;
    @(posedge clk);
    #1;
    bus.dpu_load_cmd = 1'b0;
    bus.nxt_cmd = 8'h00;
    for (int c = 1; c <= RST_AT + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == RST_AT) begin
        chk("midrst_busy", 64'(busy), 64'd1);
        chk("midrst_state", 64'(dbg.state), 64'(RST_STATE));
        rst = 1'b1;
      end else if (c == RST_AT + 1) begin
        rst = 1'b0;
        chk_all_zero("midrst_after");
      end
    end
    rd_delay = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.send_request || done || busy) bad++;
    end
    chk("midrst_quiet", 64'(bad), 64'd0);
    chk("midrst_no_write", 64'(wr_cnt - base), 64'd0);

    mem[3] = 32'h000000FF;
    run_op("post_rst_inc", 8'h83, 5'd3, 32'h00000100, 5, 0, 8'h00, sr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
